// File: rtl/inst_fetcher.sv
// inst_fetcher: one-outstanding-request instruction fetch FSM; optional direct-mapped icache under `ICACHE_EN
module inst_fetcher #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          IC_IDX_W = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic        queue_full,
    output logic        iq_inst_valid,
    output logic [31:0] iq_inst,
    output logic [31:0] iq_pc,
    output logic        mc_req,
    output logic [31:0] mc_addr,
    input  logic        mc_done,
    input  logic [31:0] mc_data,
    input  logic        jump_en,
    input  logic [31:0] jump_pc
);
    typedef enum logic [1:0] {IDLE, FETCH, DISCARD} state_t;
    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] mc_addr_q, mc_addr_d;
    logic [31:0] iq_inst_q, iq_inst_d;
    logic [31:0] iq_pc_q, iq_pc_d;
    logic        mc_req_q, mc_req_d;
    logic        iq_valid_q, iq_valid_d;
    logic        hit, issue, fill, emit_miss, emit_hit;
    logic [31:0] hit_data;
    assign issue     = rdy && state_q == IDLE && !jump_en && !queue_full;
    assign fill      = rdy && state_q != IDLE && mc_done;
    assign emit_miss = fill && !jump_en && state_q == FETCH;
    assign emit_hit  = issue && hit;
`ifdef ICACHE_EN
    localparam int LINES = 1 << IC_IDX_W;
    localparam int TAG_W = 30 - IC_IDX_W;
    logic [31:0]         data_q [LINES];
    logic [TAG_W-1:0]    tag_q  [LINES];
    logic [LINES-1:0]    valid_q;
    logic [IC_IDX_W-1:0] rd_idx, wr_idx;
    assign rd_idx   = pc_q[IC_IDX_W+1:2];
    assign wr_idx   = mc_addr_q[IC_IDX_W+1:2];
    assign hit      = valid_q[rd_idx] && tag_q[rd_idx] == pc_q[31:IC_IDX_W+2];
    assign hit_data = data_q[rd_idx];
    // every returned word fills its line, even when the fetch was squashed
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
        end else if (fill) begin
            valid_q[wr_idx] <= 1'b1;
            data_q[wr_idx]  <= mc_data;
            tag_q[wr_idx]   <= mc_addr_q[31:IC_IDX_W+2];
        end
    end
`else
    logic unused_cfg;
    assign unused_cfg = ^IC_IDX_W;
    assign hit        = 1'b0;
    assign hit_data   = '0;
`endif
    // state and output registers; rdy=0 is handled by the _d logic holding values
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            pc_q       <= RESET_PC;
            mc_req_q   <= 1'b0;
            mc_addr_q  <= '0;
            iq_valid_q <= 1'b0;
            iq_inst_q  <= '0;
            iq_pc_q    <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            mc_req_q   <= mc_req_d;
            mc_addr_q  <= mc_addr_d;
            iq_valid_q <= iq_valid_d;
            iq_inst_q  <= iq_inst_d;
            iq_pc_q    <= iq_pc_d;
        end
    end
    // next state and pc: jump beats a returning word, which beats a new issue
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        if (rdy && jump_en) begin
            pc_d    = jump_pc;
            state_d = fill ? IDLE : (state_q == FETCH ? DISCARD : state_q);
        end else if (fill) begin
            state_d = IDLE;
            pc_d    = state_q == FETCH ? pc_q + 32'd4 : pc_q;
        end else if (issue) begin
            state_d = hit ? IDLE : FETCH;
            pc_d    = hit ? pc_q + 32'd4 : pc_q;
        end
    end
    // registered outputs: request held until the word returns, queue pulse on delivery
    always_comb begin
        mc_req_d   = fill ? 1'b0 : ((issue && !hit) ? 1'b1 : mc_req_q);
        mc_addr_d  = (issue && !hit) ? pc_q : mc_addr_q;
        iq_valid_d = emit_miss || emit_hit;
        iq_inst_d  = emit_miss ? mc_data : (emit_hit ? hit_data : iq_inst_q);
        iq_pc_d    = emit_miss ? mc_addr_q : (emit_hit ? pc_q : iq_pc_q);
    end
    assign iq_inst_valid = iq_valid_q;
    assign iq_inst       = iq_inst_q;
    assign iq_pc         = iq_pc_q;
    assign mc_req        = mc_req_q;
    assign mc_addr       = mc_addr_q;
endmodule

// File: doc/inst_fetcher.md
INST_FETCHER -- requirements
Module: inst_fetcher

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, PC loaded on reset.
REQ-002 SHALL have parameter IC_IDX_W, default 4, icache index width (2^IC_IDX_W lines); used only when ICACHE_EN is defined.
REQ-003 SHALL have port clk  in  1  clock, rising edge.
REQ-004 SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-005 SHALL have port rdy  in  1  global enable; low freezes all state.
REQ-006 SHALL have port queue_full  in  1  instruction queue full; blocks new fetch issue.
REQ-007 SHALL have port iq_inst_valid  out  1  one-cycle pulse: iq_inst/iq_pc valid for the queue.
REQ-008 SHALL have port iq_inst  out  32  fetched instruction word.
REQ-009 SHALL have port iq_pc  out  32  address of iq_inst.
REQ-010 SHALL have port mc_req  out  1  memory read request, level, held until mc_done.
REQ-011 SHALL have port mc_addr  out  32  word address of request, stable while mc_req high.
REQ-012 SHALL have port mc_done  in  1  one-cycle pulse: mc_data valid.
REQ-013 SHALL have port mc_data  in  32  returned instruction word.
REQ-014 SHALL have port jump_en  in  1  redirect strobe (mispredict/jump).
REQ-015 SHALL have port jump_pc  in  32  redirect target.

Function
REQ-016 SHALL implement FSM states IDLE, FETCH, DISCARD; all outputs registered.
REQ-017 IDLE, jump_en=0, queue_full=0, miss: SHALL set mc_req=1, mc_addr=pc, go FETCH.
REQ-018 IDLE with queue_full=1: SHALL issue nothing, hold pc, stay IDLE.
REQ-019 FETCH, mc_done=1, jump_en=0: SHALL drop mc_req, pulse iq_inst_valid next cycle with iq_inst=mc_data, iq_pc=request addr, pc+=4, go IDLE.
REQ-020 Miss latency SHALL be: mc_req asserted the cycle after issue decision; iq_inst_valid the cycle after mc_done.
REQ-021 Output on mc_done SHALL NOT be gated by queue_full (queue reserves two slots of slack).
REQ-022 jump_en in IDLE SHALL load pc=jump_pc, emit nothing that cycle, issue nothing that cycle.
REQ-023 jump_en in FETCH without mc_done SHALL load pc=jump_pc, keep mc_req/mc_addr unchanged, go DISCARD.
REQ-024 jump_en with mc_done in same cycle (FETCH or DISCARD) SHALL drop mc_req, suppress iq_inst_valid, load pc=jump_pc, go IDLE.
REQ-025 DISCARD on mc_done SHALL drop mc_req, emit nothing, go IDLE; further jump_en in DISCARD SHALL only update pc.
REQ-026 pc increment SHALL be modulo 2^32 (0xFFFF_FFFC + 4 = 0).
REQ-027 rdy=0 SHALL freeze FSM, pc, cache and all outputs except iq_inst_valid, which SHALL be 0; mc_done/jump_en in that cycle SHALL be ignored (controller must not pulse mc_done while rdy=0).
REQ-028 Priority SHALL be rst > rdy=0 > jump_en > mc_done > issue.

Reset
REQ-029 On rst: state=IDLE, pc=RESET_PC, mc_req=0, mc_addr=0, iq_inst_valid=0, iq_inst=0, iq_pc=0; cache valid bits all 0.
REQ-030 rst during FETCH/DISCARD SHALL abandon request immediately (mc_req=0 next cycle); memory controller is reset by the same rst.

Configuration
REQ-031 Macro ICACHE_EN: when defined, SHALL include direct-mapped icache, 2^IC_IDX_W one-word lines, index pc[IC_IDX_W+1:2], tag pc[31:IC_IDX_W+2], valid bit per line.
REQ-032 With ICACHE_EN, IDLE hit (queue_full=0, jump_en=0) SHALL emit iq_inst_valid next cycle, pc+=4, no mc_req, stay IDLE (one instruction per cycle on hits).
REQ-033 With ICACHE_EN, every mc_done (FETCH or DISCARD, even with jump_en) SHALL write the line for the request address.
REQ-034 Without ICACHE_EN, every fetch SHALL be a miss; no cache storage SHALL be synthesized.

Verification
REQ-035 Reset, queue_full=0, mem latency 3: mc_req=1, mc_addr=0x0 cycle 1; mc_done with 0x00000013 -> iq_inst_valid pulse, iq_pc=0x0, next mc_addr=0x4.
REQ-036 jump_en, jump_pc=0x100 during FETCH of 0x8 -> mc_addr stays 0x8 until mc_done; no iq_inst_valid for 0x8; next request mc_addr=0x100.
REQ-037 jump_en coincident with mc_done -> iq_inst_valid stays 0; next mc_addr=jump_pc.
REQ-038 queue_full=1 held in IDLE for 5 cycles -> mc_req stays 0, pc unchanged; release -> request issued next cycle.
REQ-039 ICACHE_EN: loop 0x0..0xC fetched twice (jump to 0x0) -> second pass 4 back-to-back iq_inst_valid cycles, mc_req=0 throughout.
REQ-040 rdy=0 for 3 cycles mid-FETCH -> all state held, iq_inst_valid=0; resumes identically after rdy=1.
